// File: rtl/touch_resp_pkg.sv
// touch_resp_pkg: channel codes, command bit positions and FSM states for the touch ADC responder
package touch_resp_pkg;

    localparam logic [2:0] CH_Y    = 3'b001;
    localparam logic [2:0] CH_Z1   = 3'b011;
    localparam logic [2:0] CH_Z2   = 3'b100;
    localparam logic [2:0] CH_X    = 3'b101;
    localparam logic [2:0] CH_AUX0 = 3'b010;
    localparam logic [2:0] CH_AUX1 = 3'b110;

    localparam int CMD_A_HI  = 6;
    localparam int CMD_A_LO  = 4;
    localparam int CMD_MODE  = 3;
    localparam int CMD_PD_HI = 1;
    localparam int CMD_PD_LO = 0;

    typedef enum logic [1:0] {IDLE, CMD, BUSY, DATA} state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rise/fall pulses taken on the synchronized level
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Synchronizer free-runs through reset so the level is already valid when reset releases
    always_ff @(posedge i_clk) r_sync <= {r_sync[STAGES-2:0], i_d};

    // Previous level follows the synchronized level unconditionally, so no false edge appears after reset
    always_ff @(posedge i_clk) r_prev <= r_sync[STAGES-1];

    assign o_q    = r_sync[STAGES-1];
    assign o_rise = o_q & ~r_prev;
    assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/touch_adc_responder.sv
// touch_adc_responder: XPT2046-style SPI touch ADC emulator (define TOUCH_AUX_CHAN_EN for aux channels 010/110)
module touch_adc_responder
    import touch_resp_pkg::*;
#(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sclk,
    input  logic              reset,
    input  logic              cs_n,
    input  logic              sck,
    input  logic              mosi,
    output logic              miso,
    output logic              busy,
    output logic              pen_irq_n,
    input  logic              touch,
    input  logic [DATA_W-1:0] x_val,
    input  logic [DATA_W-1:0] y_val,
    input  logic [DATA_W-1:0] z1_val,
    input  logic [DATA_W-1:0] z2_val,
`ifdef TOUCH_AUX_CHAN_EN
    input  logic [DATA_W-1:0] aux0_val,
    input  logic [DATA_W-1:0] aux1_val,
`endif
    output logic              cmd_strobe,
    output logic [7:0]        last_cmd,
    output logic              frame_err
);

    localparam int DCNT_W = $clog2(DATA_W);

    logic                   w_cs_q, w_cs_rise, w_cs_fall;
    logic                   w_sck_q, w_sck_rise, w_sck_fall;
    logic                   w_mosi_q, w_unused;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [7:0]             w_byte;
    logic [DATA_W-1:0]      w_sel;

    state_t              r_state, w_state_nxt;
    logic [2:0]          r_cnt, w_cnt_nxt;
    logic [6:0]          r_sh, w_sh_nxt;
    logic [7:0]          r_cmd, w_cmd_nxt;
    logic [1:0]          r_pd, w_pd_nxt;
    logic [DATA_W-1:0]   r_tx, w_tx_nxt;
    logic [DCNT_W-1:0]   r_dcnt, w_dcnt_nxt;
    logic                r_miso, w_miso_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_strobe, w_strobe_nxt;
    logic                r_ferr, w_ferr_nxt;
    logic                r_pen;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .i_clk  (sclk),
        .i_d    (cs_n),
        .o_q    (w_cs_q),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .i_clk  (sclk),
        .i_d    (sck),
        .o_q    (w_sck_q),
        .o_rise (w_sck_rise),
        .o_fall (w_sck_fall)
    );

    assign w_unused = w_sck_q;

    // Data line only needs the same delay as sck so samples stay aligned with the synchronized edges
    always_ff @(posedge sclk) r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};

    assign w_mosi_q = r_mosi_sync[SYNC_STAGES-1];
    assign w_byte   = {r_sh, w_mosi_q};

    // Channel select from the address field of the byte completing now
    always_comb begin
        w_sel = '0;
        case (w_byte[CMD_A_HI:CMD_A_LO])
            CH_Y:    w_sel = y_val;
            CH_Z1:   w_sel = z1_val;
            CH_Z2:   w_sel = z2_val;
            CH_X:    w_sel = x_val;
`ifdef TOUCH_AUX_CHAN_EN
            CH_AUX0: w_sel = aux0_val;
            CH_AUX1: w_sel = aux1_val;
`else
            CH_AUX0, CH_AUX1: w_sel = '0;
`endif
            default: w_sel = '0;
        endcase
    end

    // Next-state and datapath updates; a cs_n rise overrides any simultaneous sck activity
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_sh_nxt     = r_sh;
        w_cmd_nxt    = r_cmd;
        w_pd_nxt     = r_pd;
        w_tx_nxt     = r_tx;
        w_dcnt_nxt   = r_dcnt;
        w_miso_nxt   = r_miso;
        w_busy_nxt   = r_busy;
        w_strobe_nxt = 1'b0;
        w_ferr_nxt   = 1'b0;
        if (w_cs_rise) begin
            w_state_nxt = IDLE;
            w_miso_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
            w_ferr_nxt  = (r_state == BUSY) || (r_state == DATA);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        w_state_nxt = CMD;
                        w_cnt_nxt   = 3'd0;
                    end
                end
                CMD: begin
                    if (w_sck_rise) begin
                        if (r_cnt == 3'd0) begin
                            if (w_mosi_q) begin
                                w_sh_nxt  = 7'd1;
                                w_cnt_nxt = 3'd1;
                            end
                        end else if (r_cnt == 3'd7) begin
                            w_cmd_nxt    = w_byte;
                            w_pd_nxt     = w_byte[CMD_PD_HI:CMD_PD_LO];
                            w_strobe_nxt = 1'b1;
                            w_tx_nxt     = w_byte[CMD_MODE] ? (w_sel >> (DATA_W - 8)) << (DATA_W - 8) : w_sel;
                            w_dcnt_nxt   = w_byte[CMD_MODE] ? DCNT_W'(7) : DCNT_W'(DATA_W - 1);
                            w_cnt_nxt    = 3'd0;
                            w_state_nxt  = BUSY;
                        end else begin
                            w_sh_nxt  = {r_sh[5:0], w_mosi_q};
                            w_cnt_nxt = r_cnt + 3'd1;
                        end
                    end
                end
                BUSY: begin
                    if (w_sck_fall) begin
                        if (!r_busy) begin
                            w_busy_nxt = 1'b1;
                            w_miso_nxt = 1'b0;
                        end else begin
                            w_busy_nxt  = 1'b0;
                            w_miso_nxt  = r_tx[DATA_W-1];
                            w_tx_nxt    = {r_tx[DATA_W-2:0], 1'b0};
                            w_state_nxt = DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_sck_fall) begin
                        if (r_dcnt == '0) begin
                            w_miso_nxt  = 1'b0;
                            w_state_nxt = CMD;
                        end else begin
                            w_miso_nxt = r_tx[DATA_W-1];
                            w_tx_nxt   = {r_tx[DATA_W-2:0], 1'b0};
                            w_dcnt_nxt = r_dcnt - DCNT_W'(1);
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State and datapath registers; pen interrupt is masked while selected or when power-down bits disable it
    always_ff @(posedge sclk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= 3'd0;
            r_sh     <= 7'd0;
            r_cmd    <= 8'h00;
            r_pd     <= 2'b00;
            r_tx     <= '0;
            r_dcnt   <= '0;
            r_miso   <= 1'b0;
            r_busy   <= 1'b0;
            r_strobe <= 1'b0;
            r_ferr   <= 1'b0;
            r_pen    <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sh     <= w_sh_nxt;
            r_cmd    <= w_cmd_nxt;
            r_pd     <= w_pd_nxt;
            r_tx     <= w_tx_nxt;
            r_dcnt   <= w_dcnt_nxt;
            r_miso   <= w_miso_nxt;
            r_busy   <= w_busy_nxt;
            r_strobe <= w_strobe_nxt;
            r_ferr   <= w_ferr_nxt;
            r_pen    <= ~(touch & (r_pd == 2'b00) & w_cs_q);
        end
    end

    assign miso       = r_miso;
    assign busy       = r_busy;
    assign pen_irq_n  = r_pen;
    assign cmd_strobe = r_strobe;
    assign last_cmd   = r_cmd;
    assign frame_err  = r_ferr;

endmodule

// File: doc/touch_adc_responder.md
Name: touch_adc_responder

Overview:
- SPI-slave counterpart to the front-panel display master's touch interface; emulates an XPT2046-style touch ADC.
- The master drives chip-select, SCK and command data (its SDO) and reads conversion results back on its SDI.
- This block decodes the 8-bit command, returns a 12- or 8-bit value for the selected channel and drives the pen-interrupt line.
- Used for in-FPGA panel emulation and bench closure of the display master.

Parameters:
- DATA_W, 12, full-resolution result width.
- SYNC_STAGES, 2, synchronizer depth on cs_n, sck and mosi.

Ports:
- sclk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- cs_n  in  1  chip select from master, active low; asynchronous to sclk.
- sck  in  1  serial clock from master; asynchronous to sclk.
- mosi  in  1  command data from master.
- miso  out  1  result data to master.
- busy  out  1  high during the busy slot.
- pen_irq_n  out  1  pen interrupt, active low.
- touch  in  1  pen-down indication.
- x_val, y_val, z1_val, z2_val  in  DATA_W each  channel values.
- cmd_strobe  out  1  one-cycle pulse when a command byte completes.
- last_cmd  out  8  last decoded command byte.
- frame_err  out  1  one-cycle pulse when cs_n rises mid-conversion.

Behaviour:
- Reset (reset==0 on a sclk edge): miso=0, busy=0, pen_irq_n=1, cmd_strobe=0, last_cmd=8'h00, frame_err=0, state=IDLE, PD=2'b00 (IRQ enabled).
- Input sync: cs_n, sck and mosi each pass through SYNC_STAGES flops; edges are detected on the synchronized sck.
  - Action latency is SYNC_STAGES+1 sclk cycles after the pin edge.
  - Master SCK high and low times must each be ≥ SYNC_STAGES+2 sclk cycles.
- Master samples miso on SCK rising edges. The block samples mosi on SCK rising edges and updates miso on SCK falling edges.
- Command byte: bit7 = start, bits6:4 = A2..A0, bit3 = MODE (1 → 8-bit), bit2 = SER/DFR (stored, ignored), bits1:0 = PD.
- States:
  - IDLE: cs_n high; miso=0. On cs_n fall → CMD.
  - CMD: on each rising edge, shift in mosi.
    - Leading zeros are discarded until a 1 (start bit) is seen; then 7 more bits are collected.
    - On the 8th bit: latch last_cmd and PD, pulse cmd_strobe, snapshot the selected channel → BUSY.
  - BUSY: on the next falling edge, miso=0 and busy=1. On the following falling edge, busy=0, miso=result MSB → DATA.
  - DATA: shift one bit per falling edge, MSB first, for DATA_W bits (8 if MODE=1). Then miso=0 → CMD.
    - This allows back-to-back commands without deasserting cs_n.
  - cs_n rising in any state → IDLE with miso=0 and busy=0. If the state was BUSY or DATA, pulse frame_err.
- Channel map (A2..A0): 001→y_val, 011→z1_val, 100→z2_val, 101→x_val; all others return 0.
- 8-bit mode returns snapshot[DATA_W-1:DATA_W-8].
- The snapshot is taken once, so input changes during DATA do not affect the transmitted word.
- pen_irq_n = ~(touch & PD==2'b00 & cs_n_sync); it is forced high while a frame is selected and is registered.
- A start bit arriving exactly as cs_n rises is ignored (the cs_n rise wins).
- Reset asserted mid-frame: immediate return to reset values; the next frame needs a new cs_n fall.

Optional Feature:
- TOUCH_AUX_CHAN_EN defined: adds inputs aux0_val and aux1_val (DATA_W each), mapped to channel codes 010 and 110.
- Undefined: those ports are absent and codes 010/110 return 0.

Decomposition:
- Package touch_resp_pkg holds:
  - Channel code constants: CH_Y=3'b001, CH_Z1=3'b011, CH_Z2=3'b100, CH_X=3'b101, CH_AUX0=3'b010, CH_AUX1=3'b110.
  - Command bit-position constants.
  - State enum: IDLE, CMD, BUSY, DATA.
- One sub-module, spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall pulse generation, instantiated for sck and cs_n; mosi is synchronized only.

Test Plan:
- Reset mid-frame: assert reset after 4 command bits → all outputs at reset values within 1 cycle; the next full frame works normally.
- Single 12-bit read: x_val=12'hA5C, command 8'hD0 (X, 12-bit, PD=00), 24 SCK → master reads busy 0 then 1010_0101_1100; cmd_strobe pulses once; last_cmd=8'hD0.
- 8-bit mode: y_val=12'h3F1, command 8'h98 → 8 bits returned = 8'h3F, then zeros.
- Back-to-back: commands 8'hB0 then 8'hC0 with cs_n held low (z1=12'h123, z2=12'h456) → 12'h123 then 12'h456; two cmd_strobe pulses.
- Abort and snapshot: change x_val from 12'h800 to 12'h001 after 3 data bits, then raise cs_n → the bits sent so far are 1,0,0; frame_err pulses once; miso=0.
- Pen IRQ: touch=1 with PD=00 → pen_irq_n=0; forced to 1 while cs_n is low; after command 8'hD3 (PD=11), touch=1 → pen_irq_n stays 1.
